// File: rtl/sop_sweep_driver.sv
// Sweeps all 512 input combinations across a reference and a minimized SOP circuit,
// storing the reference truth table and tallying minterms and disagreements.
module sop_sweep_driver #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ref_out,
  input  logic       dut_out,
  output logic [8:0] vec,
  output logic       busy,
  output logic       done,
  output logic [9:0] ones_count,
  output logic [9:0] mism_count,
  output logic       mismatch,
  output logic [8:0] first_bad,
  input  logic [8:0] tt_addr,
  output logic       tt_data
);

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(SETTLE - 1);

  state_t     state_reg, state_next;
  logic [8:0] vec_reg, vec_next;
  logic [3:0] hold_reg, hold_next;
  logic [9:0] ones_reg, ones_next;
  logic [9:0] mism_reg, mism_next;
  logic       mismatch_reg, mismatch_next;
  logic [8:0] first_bad_reg, first_bad_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       tt_data_reg;
  logic       tbl_we;
  logic [511:0] tbl_reg;

  always_comb begin
    state_next     = state_reg;
    vec_next       = vec_reg;
    hold_next      = hold_reg;
    ones_next      = ones_reg;
    mism_next      = mism_reg;
    mismatch_next  = mismatch_reg;
    first_bad_next = first_bad_reg;
    tbl_we         = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next     = HOLD;
          vec_next       = 9'd0;
          hold_next      = 4'd0;
          ones_next      = 10'd0;
          mism_next      = 10'd0;
          mismatch_next  = 1'b0;
          first_bad_next = 9'd0;
        end
      end
      HOLD: begin
        hold_next = hold_reg + 4'd1;
        if (hold_reg == HOLD_LAST) state_next = SAMPLE;
      end
      SAMPLE: begin
        tbl_we    = 1'b1;
        ones_next = ones_reg + {9'd0, ref_out};
        if (ref_out != dut_out) begin
          mism_next = mism_reg + 10'd1;
          if (!mismatch_reg) begin
            mismatch_next  = 1'b1;
            first_bad_next = vec_reg;
          end
        end
        // The last vector stays on the bus so the board shows where the sweep ended.
        if (vec_reg == 9'd511) begin
          state_next = DONE;
        end else begin
          vec_next   = vec_reg + 9'd1;
          hold_next  = 4'd0;
          state_next = HOLD;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == HOLD) || (state_next == SAMPLE);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      vec_reg       <= 9'd0;
      hold_reg      <= 4'd0;
      ones_reg      <= 10'd0;
      mism_reg      <= 10'd0;
      mismatch_reg  <= 1'b0;
      first_bad_reg <= 9'd0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      tt_data_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      vec_reg       <= vec_next;
      hold_reg      <= hold_next;
      ones_reg      <= ones_next;
      mism_reg      <= mism_next;
      mismatch_reg  <= mismatch_next;
      first_bad_reg <= first_bad_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      tt_data_reg   <= tbl_reg[tt_addr];
    end
  end

  // Table is kept in flops so reset can clear all 512 entries in one cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 512; gi++) begin : g_tbl
      always_ff @(posedge clk) begin
        if (!rst_n)
          tbl_reg[gi] <= 1'b0;
        else if (tbl_we && (vec_reg == 9'(gi)))
          tbl_reg[gi] <= ref_out;
      end
    end
  endgenerate

  assign vec        = vec_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign ones_count = ones_reg;
  assign mism_count = mism_reg;
  assign mismatch   = mismatch_reg;
  assign first_bad  = first_bad_reg;
  assign tt_data    = tt_data_reg;

endmodule

// File: tb/tb_sop_sweep_driver.sv
// Randomized self-checking bench for sop_sweep_driver; the lab functions and their
// expected tallies come from a truth-table model held in plain arrays.
module tb_sop_sweep_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start1, start3;
  logic       ref1, dut1, ref3, dut3;
  logic [8:0] vec1, vec3, first_bad1, first_bad3, tt_addr1, tt_addr3;
  logic       busy1, done1, mismatch1, tt_data1, busy3, done3, mismatch3, tt_data3;
  logic [9:0] ones1, mism1, ones3, mism3;

  int errors = 0;
  int checks = 0;
  int mode = 0;
  bit rnd_ref[512];
  bit rnd_err[512];

  sop_sweep_driver #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ref_out(ref1), .dut_out(dut1),
    .vec(vec1), .busy(busy1), .done(done1), .ones_count(ones1), .mism_count(mism1),
    .mismatch(mismatch1), .first_bad(first_bad1), .tt_addr(tt_addr1), .tt_data(tt_data1)
  );

  sop_sweep_driver #(.SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .ref_out(ref3), .dut_out(dut3),
    .vec(vec3), .busy(busy3), .done(done3), .ones_count(ones3), .mism_count(mism3),
    .mismatch(mismatch3), .first_bad(first_bad3), .tt_addr(tt_addr3), .tt_data(tt_data3)
  );

  // Lab functions: mode 0 a, 1 a with one bad row, 2 inverted dut, 3 random tables
  function automatic logic fn_ref(input logic [8:0] v);
    if (mode == 3) return rnd_ref[v];
    return v[8];
  endfunction

  function automatic logic fn_dut(input logic [8:0] v);
    logic r;
    r = fn_ref(v);
    case (mode)
      1: return r ^ (v == 9'h0AB);
      2: return ~r;
      3: return r ^ rnd_err[v];
      default: return r;
    endcase
  endfunction

  always @(negedge clk) begin
    ref1 = fn_ref(vec1);
    dut1 = fn_dut(vec1);
    ref3 = fn_ref(vec3);
    dut3 = fn_dut(vec3);
  end

  task automatic run_sweep1(input bit pulse, output int edges);
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    edges = -1;
    for (int n = 1; n <= 4000; n++) begin
      @(posedge clk);
      #1;
      if (pulse) start1 = (n % 300 == 150);
      if (done1) begin
        edges = n;
        break;
      end
    end
    start1 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; tt_addr1 = 9'h100; tt_addr3 = 9'h1FF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vec1, busy1, done1, ones1, mism1, mismatch1, first_bad1, tt_data1} !== 42'd0) begin
      errors++;
      $display("FAIL reset_u1: got vec=%h busy=%b done=%b ones=%0d mism=%0d mm=%b fb=%h tt=%b required all 0",
               vec1, busy1, done1, ones1, mism1, mismatch1, first_bad1, tt_data1);
    end
    checks++;
    if ({vec3, busy3, done3, ones3, mism3, mismatch3, first_bad3, tt_data3} !== 42'd0) begin
      errors++;
      $display("FAIL reset_u3: got vec=%h busy=%b done=%b ones=%0d mism=%0d mm=%b fb=%h tt=%b required all 0",
               vec3, busy3, done3, ones3, mism3, mismatch3, first_bad3, tt_data3);
    end
    @(negedge clk) rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_sweep(input int m, input bit pulse);
    int exp_ones, exp_mism, edges;
    logic [8:0] exp_first;
    mode = m;
    exp_ones = 0; exp_mism = 0; exp_first = 9'd0;
    for (int v = 0; v < 512; v++) begin
      exp_ones += int'(fn_ref(9'(v)));
      if (fn_ref(9'(v)) != fn_dut(9'(v))) begin
        if (exp_mism == 0) exp_first = 9'(v);
        exp_mism++;
      end
    end
    run_sweep1(pulse, edges);
    checks++;
    if (edges != 1024) begin
      errors++;
      $display("FAIL sweep_done_edge mode%0d: got %0d required 1024", m, edges);
    end
    checks++;
    if (ones1 !== 10'(exp_ones)) begin
      errors++;
      $display("FAIL ones_count mode%0d: got %0d required %0d", m, ones1, exp_ones);
    end
    checks++;
    if (mism1 !== 10'(exp_mism)) begin
      errors++;
      $display("FAIL mism_count mode%0d: got %0d required %0d", m, mism1, exp_mism);
    end
    checks++;
    if (mismatch1 !== (exp_mism != 0)) begin
      errors++;
      $display("FAIL mismatch mode%0d: got %b required %b", m, mismatch1, exp_mism != 0);
    end
    checks++;
    if (first_bad1 !== exp_first) begin
      errors++;
      $display("FAIL first_bad mode%0d: got %h required %h", m, first_bad1, exp_first);
    end
    checks++;
    if (busy1 !== 1'b0 || vec1 !== 9'd511) begin
      errors++;
      $display("FAIL done_state mode%0d: got busy=%b vec=%h required busy=0 vec=1ff", m, busy1, vec1);
    end
    $display("sweep mode=%0d pulse=%0d edges=%0d ones=%0d mism=%0d first_bad=%h",
             m, pulse, edges, ones1, mism1, first_bad1);
  endtask

  task automatic test_table_read;
    logic [8:0] addrs[$];
    addrs = '{9'h100, 9'h0FF};
    for (int k = 0; k < 6; k++) addrs.push_back(9'($urandom_range(0, 511)));
    foreach (addrs[k]) begin
      @(negedge clk) tt_addr1 = addrs[k];
      @(posedge clk);
      #1;
      checks++;
      if (tt_data1 !== fn_ref(addrs[k])) begin
        errors++;
        $display("FAIL tt_read addr=%h: got %b required %b", addrs[k], tt_data1, fn_ref(addrs[k]));
      end
    end
    $display("table read: %0d addresses", addrs.size());
  endtask

  task automatic test_random;
    for (int it = 0; it < 3; it++) begin
      foreach (rnd_ref[v]) begin
        rnd_ref[v] = 1'($urandom_range(0, 1));
        rnd_err[v] = ($urandom_range(0, 63) == 0);
      end
      test_sweep(3, it == 1);
      test_table_read;
    end
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    mode = 0;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      if (vec1 == 9'h100) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_reach: got no vec=100 required vec=100 within 1000 cycles");
    end
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({vec1, busy1, done1, ones1, mism1, mismatch1, first_bad1, tt_data1} !== 42'd0) begin
      errors++;
      $display("FAIL reset_mid: got vec=%h busy=%b done=%b ones=%0d mism=%0d mm=%b fb=%h tt=%b required all 0",
               vec1, busy1, done1, ones1, mism1, mismatch1, first_bad1, tt_data1);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk) tt_addr1 = (k == 0) ? 9'h0FE : 9'($urandom_range(0, 511));
      @(posedge clk);
      #1;
      checks++;
      if (tt_data1 !== 1'b0 || busy1 !== 1'b0 || vec1 !== 9'd0) begin
        errors++;
        $display("FAIL reset_cleared addr=%h: got tt=%b busy=%b vec=%h required 0 0 0",
                 tt_addr1, tt_data1, busy1, vec1);
      end
    end
    $display("reset mid-sweep: checked");
  endtask

  task automatic test_settle3;
    int edges, run, bad;
    logic [8:0] prev;
    mode = 0;
    @(negedge clk) start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    prev = vec3; run = 1; bad = 0; edges = -1;
    for (int n = 1; n <= 9000; n++) begin
      @(posedge clk);
      #1;
      if (done3) begin
        edges = n;
        break;
      end
      if (vec3 == prev) run++;
      else begin
        if (run != 4 || vec3 != prev + 9'd1) bad++;
        prev = vec3;
        run = 1;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL settle3_hold: got %0d bad vector holds required 0", bad);
    end
    checks++;
    if (edges != 2048 || ones3 !== 10'd256) begin
      errors++;
      $display("FAIL settle3_done: got edge=%0d ones=%0d required edge=2048 ones=256", edges, ones3);
    end
    @(negedge clk) start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    checks++;
    if (done3 !== 1'b0 || busy3 !== 1'b1 || ones3 !== 10'd0 || mism3 !== 10'd0 || vec3 !== 9'd0) begin
      errors++;
      $display("FAIL restart_from_done: got done=%b busy=%b ones=%0d mism=%0d vec=%h required 0 1 0 0 0",
               done3, busy3, ones3, mism3, vec3);
    end
    $display("settle3 sweep edges=%0d restart checked", edges);
  endtask

  initial begin
    test_reset;
    test_sweep(0, 0);
    test_table_read;
    test_sweep(1, 0);
    test_sweep(2, 1);
    test_random;
    test_sweep(0, 0);
    test_reset_mid;
    test_settle3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
